// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Definitions shared by the 7-segment display path:
//   - state_e      : conversion FSM states (idle / shifting / committing)
//   - NumDigits    : number of BCD digits on the display
//   - BcdW         : width of the packed BCD word (4 bits per digit)
//   - SEG_BLANK    : all segments off (active-low)
//   - SEG_0..SEG_9 : active-low {a,b,c,d,e,f,g} codes for the decimal digits
//   - seg7_code()  : nibble -> segment code. Non-decimal nibbles return SEG_BLANK.
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned BcdW      = 4 * NumDigits;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;

  function automatic logic [6:0] seg7_code(input logic [3:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter. One shift per clock,
// VALUE_W shifts per conversion.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   start_i  : load value_i, clear the BCD word and start shifting
//   value_i  : binary value, sampled when start_i is high
//   done_o   : high during the cycle whose edge performs the final shift
//   bcd_o    : packed BCD result, digit 0 in bits [3:0]; final once done_o
//              has been seen and until the next start_i
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned VALUE_W = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               done_o,
  output logic [BcdW-1:0]    bcd_o
);

  localparam int unsigned    CntW    = $clog2(VALUE_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(VALUE_W - 1);

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0]    bcd_q, bcd_d;
  logic [BcdW-1:0]    bcd_adj;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               run_q, run_d;

  // Add-3 correction on every nibble >= 5, applied before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NumDigits; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      bin_d = value_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      // Shift {bcd, bin} left by one as a single word.
      bcd_d = {bcd_adj[BcdW-2:0], bin_q[VALUE_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == LastCnt) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == LastCnt);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Display controller: converts a binary count to BCD, commits all four digits
// atomically and time-multiplexes a 4-digit active-low 7-segment bus.
// Ports:
//   clk         : clock
//   reset       : synchronous active-high reset
//   value       : binary count to display
//   value_valid : single-cycle load strobe for value
//   blank_lz    : blank leading zeros (digits 3..1), sampled live
//   busy        : conversion in progress (SHIFT or DONE)
//   enable      : active-low one-hot anode select, bit 0 = rightmost digit
//   seg         : active-low segments {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned VALUE_W     = 7,
  parameter int unsigned REFRESH_CNT = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic               blank_lz,
  output logic               busy,
  output logic [3:0]         enable,
  output logic [6:0]         seg
);

  localparam int unsigned     RefW    = $clog2(REFRESH_CNT);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CNT - 1);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               pend_q, pend_d;
  logic [VALUE_W-1:0] pend_val_q, pend_val_d;
  logic [BcdW-1:0]    digit_q, digit_d;
  logic [RefW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [1:0]         slot_q, slot_d;

  logic               conv_start;
  logic [VALUE_W-1:0] conv_val;
  logic               conv_done;
  logic [BcdW-1:0]    conv_bcd;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_bin2bcd (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (conv_start),
    .value_i (conv_val),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Conversion sequencing, pending capture and atomic commit.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    digit_d    = digit_q;
    conv_start = 1'b0;
    conv_val   = value;
    unique case (state_q)
      StIdle: begin
        if (value_valid) begin
          conv_start = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        // Latest load wins while a conversion is in flight.
        if (value_valid) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
        if (conv_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        digit_d = conv_bcd;
        pend_d  = 1'b0;
        // A load coinciding with DONE is newer than anything pending.
        if (value_valid) begin
          conv_start = 1'b1;
          state_d    = StShift;
        end else if (pend_q) begin
          conv_start = 1'b1;
          conv_val   = pend_val_q;
          state_d    = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Refresh scheduling runs freely, independent of conversions.
  always_comb begin
    if (ref_cnt_q == RefLast) begin
      ref_cnt_d = '0;
      slot_d    = slot_q + 2'd1;
    end else begin
      ref_cnt_d = ref_cnt_q + RefW'(1);
      slot_d    = slot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      digit_q    <= '0;
      ref_cnt_q  <= '0;
      slot_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      digit_q    <= digit_d;
      ref_cnt_q  <= ref_cnt_d;
      slot_q     <= slot_d;
    end
  end

  // Output decode.
  logic [NumDigits-1:0] lz;
  logic [3:0]           cur_digit;

  always_comb begin
    // lz[k]: digit k and every higher digit are zero. Digit 0 is never blanked.
    lz[NumDigits-1] = (digit_q[BcdW-1 -: 4] == 4'd0);
    for (int k = NumDigits - 2; k >= 1; k--) begin
      lz[k] = lz[k+1] && (digit_q[4*k +: 4] == 4'd0);
    end
    lz[0] = 1'b0;

    cur_digit = digit_q[{slot_q, 2'b00} +: 4];
    enable    = ~(4'b0001 << slot_q);
    if (blank_lz && lz[slot_q]) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg7_code(cur_digit);
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed self-checking bench for seg_scan_ctrl with VALUE_W=7, REFRESH_CNT=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int unsigned VW = 7;
  localparam int unsigned RC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [VW-1:0] value = '0;
  logic          value_valid = 1'b0;
  logic          blank_lz = 1'b0;
  logic          busy;
  logic [3:0]    enable;
  logic [6:0]    seg;

  int checks = 0;
  int errors = 0;

  // Reference copy of the refresh counter: edges since reset release.
  int unsigned ref_cnt = 0;

  logic [6:0] code_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0001100};

  seg_scan_ctrl #(
    .VALUE_W     (VW),
    .REFRESH_CNT (RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .enable      (enable),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ref_cnt <= 0;
    else       ref_cnt <= ref_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int cur_slot();
    return int'((ref_cnt / RC) % 4);
  endfunction

  // Expected segment pattern for slot s showing packed BCD digits dig.
  function automatic logic [6:0] exp_seg(input int s, input logic [15:0] dig, input logic blk);
    logic allz;
    allz = 1'b1;
    for (int k = s; k < 4; k++) begin
      if (dig[4*k +: 4] != 4'd0) allz = 1'b0;
    end
    if (blk && s >= 1 && allz) return 7'b1111111;
    return code_tab[dig[4*s +: 4]];
  endfunction

  task automatic check_now(input string tag, input logic [15:0] dig, input logic blk);
    int s;
    logic [3:0] e;
    s = cur_slot();
    e = ~(4'b0001 << s);
    check($sformatf("%s_en", tag), {28'd0, enable}, {28'd0, e});
    check($sformatf("%s_seg", tag), {25'd0, seg}, {25'd0, exp_seg(s, dig, blk)});
  endtask

  task automatic show_all(input string tag, input logic [15:0] dig, input logic blk);
    for (int s = 0; s < 4; s++) begin
      int guard;
      guard = 0;
      while (cur_slot() != s && guard < 32) begin
        step(1);
        guard++;
      end
      check_now($sformatf("%s_s%0d", tag, s), dig, blk);
    end
  endtask

  task automatic wait_phase(input int unsigned p);
    int guard;
    guard = 0;
    while ((ref_cnt % 16) != p && guard < 32) begin
      step(1);
      guard++;
    end
  endtask

  // Returns at the falling edge after the sampling edge (edge 0).
  task automatic load(input logic [VW-1:0] v);
    value       = v;
    value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
  endtask

  initial begin
    // Reset and scan sequence.
    step(3);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_now("rst", 16'h0000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 3 || (i % 4) == 0) check_now($sformatf("scan%0d", i), 16'h0000, 1'b0);
    end

    // value = 100: busy for 8 cycles, then 0100 on the display.
    check("t100_idle", {31'd0, busy}, 32'd0);
    load(7'd100);
    for (int i = 0; i <= 8; i++) begin
      check($sformatf("t100_busy_e%0d", i), {31'd0, busy}, {31'd0, (i < 8)});
      if (i < 8) step(1);
    end
    show_all("t100", 16'h0100, 1'b0);

    // value = 7 with leading-zero blanking, then blanking dropped.
    blank_lz = 1'b1;
    load(7'd7);
    step(8);
    check("t7_busy", {31'd0, busy}, 32'd0);
    show_all("t7_blk", 16'h0007, 1'b1);
    blank_lz = 1'b0;
    show_all("t7_noblk", 16'h0007, 1'b0);

    // Back-to-back loads: 42, 99 at +2, 58 at +4. Commit lands in slot 0.
    wait_phase(8);
    load(7'd42);
    step(1);
    value = 7'd99; value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
    step(1);
    value = 7'd58; value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
    step(3);
    check_now("t42_e7", 16'h0007, 1'b0);
    step(1);
    check_now("t42_e8", 16'h0042, 1'b0);
    check("t42_busy_e8", {31'd0, busy}, 32'd1);
    for (int e = 9; e <= 15; e++) begin
      step(1);
      check_now($sformatf("t42_e%0d", e), 16'h0042, 1'b0);
    end
    check("t58_busy_e15", {31'd0, busy}, 32'd1);
    step(1);
    check("t58_busy_e16", {31'd0, busy}, 32'd0);
    check_now("t58_e16", 16'h0058, 1'b0);
    show_all("t58", 16'h0058, 1'b0);

    // Reset in the middle of converting 127.
    load(7'd127);
    step(3);
    reset = 1'b1;
    step(1);
    check("trst_busy", {31'd0, busy}, 32'd0);
    check_now("trst", 16'h0000, 1'b0);
    reset = 1'b0;
    step(12);
    check("trst_busy_late", {31'd0, busy}, 32'd0);
    show_all("trst", 16'h0000, 1'b0);

    // Load 25, then value_valid on its DONE cycle with value = 3.
    wait_phase(8);
    load(7'd25);
    step(7);
    check_now("t25_e7", 16'h0000, 1'b0);
    value = 7'd3; value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
    check("t3_busy_e8", {31'd0, busy}, 32'd1);
    check_now("t25_e8", 16'h0025, 1'b0);
    step(7);
    check("t3_busy_e15", {31'd0, busy}, 32'd1);
    step(1);
    check("t3_busy_e16", {31'd0, busy}, 32'd0);
    show_all("t3", 16'h0003, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Display controller for the up/down counter datapath. It accepts a binary count, converts it to BCD with a sequential double-dabble engine, and time-multiplexes the shared 4-digit 7-segment bus. It owns refresh scheduling, leading-zero blanking and atomic digit update, so the counter never drives segments or anodes directly.

## Interface
- `VALUE_W`, default 7: width of the binary input. Legal range 1..13, so the result fits in 4 BCD digits.
- `REFRESH_CNT`, default 50000: clocks per digit slot. Must be ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  VALUE_W  binary count to display.
- `value_valid`  in  1  single-cycle load strobe for `value`.
- `blank_lz`  in  1  when high, leading zeros are blanked. Sampled live.
- `busy`  out  1  conversion in progress.
- `enable`  out  4  anode selects, active-low, one-hot-low. Bit 0 is the rightmost digit.
- `seg`  out  7  segments, active-low, {a,b,c,d,e,f,g}.

## Operation
- **Reset values:**
  - FSM in IDLE, `busy`=0.
  - Committed digits d3..d0 = 0; pending flag = 0.
  - Refresh counter = 0; slot = 0.
  - `enable`=4'b1110, `seg`=7'b0000001.
- **FSM states:**
  - IDLE: on `value_valid`, load `value` into the shift register, clear BCD and the shift count, go to SHIFT.
  - SHIFT: runs exactly VALUE_W cycles. Each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After the last shift, go to DONE.
  - DONE: one cycle. Copy all four BCD nibbles into d3..d0 in the same edge, so there is no partially updated display. Then go to IDLE.
- **Back-to-back loads:**
  - A `value_valid` arriving while not in IDLE is stored in a pending register and sets the pending flag.
  - If another load arrives before it is serviced, the later value overwrites it (latest wins).
  - In DONE, if the pending flag is set, the FSM goes straight to SHIFT with the pending value and clears the flag. It does not pass through IDLE.
  - If `value_valid` and DONE coincide, the incoming value is the one that restarts the conversion.
- `busy` is 1 in SHIFT and DONE.
- **Refresh scheduling:**
  - The counter runs 0..REFRESH_CNT-1 and wraps.
  - On wrap, slot advances 0→1→2→3→0.
  - The counter runs continuously, independent of the FSM.
- **Output decode** (combinational from slot, committed digits and `blank_lz`):
  - `enable` = ~(1<<slot).
  - `seg` encoding, digit→code:
    - 0 → 0000001
    - 1 → 1001111
    - 2 → 0010010
    - 3 → 0000110
    - 4 → 1001100
    - 5 → 0100100
    - 6 → 0100000
    - 7 → 0001111
    - 8 → 0000000
    - 9 → 0001100
  - Any nibble >9 decodes to 7'b1111111. This is unreachable for legal VALUE_W.
- **Blanking:** when `blank_lz`=1, digit k (k≥1) is blanked (`seg`=7'b1111111) if dk and every higher digit are 0. d0 is never blanked.
- **Reset mid-operation:** returns to reset values on the next edge, discarding any conversion in flight and any pending value.

## Timing
- Let `value_valid` be sampled at edge 0 with the FSM in IDLE:
  - SHIFT occupies edges 1..VALUE_W.
  - Commit occurs at edge VALUE_W+1 (edge 8 for default VALUE_W).
  - `busy` is 1 from edge 1 through edge VALUE_W+1 and returns to 0 after it.
- The pending restart adds VALUE_W+1 cycles per queued value.
- `enable` and `seg` change only on slot advance or on a commit edge.
- Each digit is lit for REFRESH_CNT clocks; the full frame is 4·REFRESH_CNT clocks.

## Structure
- **Shared package `seg_pkg`:**
  - The state enum {IDLE, SHIFT, DONE}.
  - `SEG_BLANK`=7'b1111111.
  - The ten digit-code constants.
  - A `seg7_code(nibble)` function, so the counter and any future display use the same table.
- **One sub-module, `bin2bcd_seq`:** holds the SHIFT datapath (shift register, add-3 stages and shift count), with a start/done handshake. `seg_scan_ctrl` owns pending, commit, refresh and decode.

## Test plan
- Release reset, REFRESH_CNT=4 → `enable` cycles 1110,1101,1011,0111 every 4 clocks; with `blank_lz`=0, `seg`=0000001 on all slots.
- `value`=100, one `value_valid` → `busy` high 8 cycles; after commit, slots 0..3 show 0000001, 0000001, 1001111, 0000001.
- `value`=7, `blank_lz`=1 → slot 0 shows 0001111; slots 1–3 are 1111111. Drop `blank_lz` → slots 1–3 show 0000001 with no new load.
- Load 42, then 99 at +2 and 58 at +4 → display commits 42 at edge 8, then 58 at edge 16; 99 never appears.
- Load 127, assert `reset` at edge 4 → on the next edge, `busy`=0 and all digits are 0, and 127 never appears.
- `value_valid` held on the DONE cycle with `value`=3 → conversion restarts with no IDLE cycle and 3 commits 8 edges later.
